// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit; LOGIC_UNIT_FLAGS_EN adds registered zero/parity flags
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             Z,
  output logic             P
);
  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] a_q, b_q, res;
  logic [2:0]       op_q;
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  always_comb begin
    res = op_q == 3'd0 ? a_q & b_q :
          op_q == 3'd1 ? a_q | b_q :
          op_q == 3'd2 ? a_q ^ b_q :
          op_q == 3'd3 ? ~(a_q & b_q) :
          op_q == 3'd4 ? ~(a_q | b_q) :
          op_q == 3'd5 ? ~(a_q ^ b_q) :
          op_q == 3'd6 ? a_q & ~b_q : a_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      C        <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          a_q  <= A;
          b_q  <= B;
          op_q <= OP;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) C <= res;
      end
    end
  end
`ifdef LOGIC_UNIT_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Z <= 1'b0;
      P <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      Z <= ~|res;
      P <= ^res;
    end
  end
`else
  assign Z = 1'b0;
  assign P = 1'b0;
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe at WIDTH 8, 32 and 1
module tb_logic_unit_pipe;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 0, in_ready, out_valid, out_ready = 1, Z, P;
  logic [7:0] A = 0, B = 0, C;
  logic [2:0] OP = 0;

  logic        v32 = 0, r32, ov32, z32, p32;
  logic [31:0] a32 = 0, b32 = 0, c32;
  logic [2:0]  op32 = 0;

  logic        v1 = 0, r1, ov1, z1, p1;
  logic [0:0]  a1 = 0, b1 = 0, c1;
  logic [2:0]  op1 = 0;

  int checks = 0, failures = 0;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .OP(OP),
    .out_valid(out_valid), .out_ready(out_ready), .C(C), .Z(Z), .P(P));

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .A(a32), .B(b32), .OP(op32),
    .out_valid(ov32), .out_ready(1'b1), .C(c32), .Z(z32), .P(p32));

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .A(a1), .B(b1), .OP(op1),
    .out_valid(ov1), .out_ready(1'b1), .C(c1), .Z(z1), .P(p1));

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA0, 8'hA5};
  logic [7:0] stall_in  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int k;
    tick();
    tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_C", C, 0);
    chk("rst_Z", Z, 0);
    chk("rst_P", P, 0);
    chk("rst_in_ready", in_ready, 1);

    // single AND transaction, plus WIDTH=32 NOR and WIDTH=1 XOR alongside
    in_valid = 1; A = 8'hF0; B = 8'h3C; OP = 3'd0;
    v32 = 1; a32 = 32'h0000FFFF; b32 = 32'h00FF0000; op32 = 3'd4;
    v1 = 1; a1 = 1'b1; b1 = 1'b0; op1 = 3'd2;
    tick();
    in_valid = 0; v32 = 0; v1 = 0;
    chk("lat_stage1_no_out", out_valid, 0);
    chk("w32_stage1_no_out", ov32, 0);
    tick();
    chk("lat_out_valid", out_valid, 1);
    chk("lat_C", C, 8'h30);
    chk("w32_out_valid", ov32, 1);
    chk("w32_C", c32, 32'hFF000000);
    chk("w1_C", c1, 1);
    tick();
    chk("lat_drain", out_valid, 0);
    chk("lat_C_hold", C, 8'h30);

    // back-to-back op sweep
    A = 8'hA5; B = 8'h0F;
    for (int i = 0; i < 9; i++) begin
      in_valid = i < 8;
      OP = 3'(i);
      tick();
      if (i >= 1) begin
        chk($sformatf("sweep_valid_%0d", i - 1), out_valid, 1);
        chk($sformatf("sweep_C_%0d", i - 1), C, sweep_exp[i - 1]);
      end
    end
    in_valid = 0;
    tick();
    chk("sweep_drained", out_valid, 0);

    // stall: offer four inputs for five cycles with out_ready low
    out_ready = 0; OP = 3'd0; B = 8'hFF; k = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = k < 4;
      A = stall_in[k < 4 ? k : 3];
      if (in_ready && in_valid) k++;
      tick();
      if (i >= 2) chk($sformatf("stall_C_%0d", i), C, 8'h11);
    end
    in_valid = 0;
    chk("stall_accepted", k, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1;
    tick();
    chk("unstall_1_valid", out_valid, 1);
    chk("unstall_1_C", C, 8'h22);
    tick();
    chk("unstall_empty", out_valid, 0);

    // flags
    in_valid = 1; OP = 3'd2; A = 8'h5A; B = 8'h5A;
    tick();
    OP = 3'd7; A = 8'h07;
    tick();
    in_valid = 0;
    chk("flag0_C", C, 8'h00);
    chk("flag0_Z", Z, FLAGS);
    chk("flag0_P", P, 0);
    tick();
    chk("flag1_C", C, 8'h07);
    chk("flag1_Z", Z, 0);
    chk("flag1_P", P, FLAGS);
    tick();

    // reset with two results in flight
    out_ready = 0; in_valid = 1; OP = 3'd1; A = 8'h0F; B = 8'hF0;
    tick();
    tick();
    in_valid = 0;
    chk("prerst_full", out_valid, 1);
    chk("prerst_in_ready", in_ready, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("postrst_valid", out_valid, 0);
    chk("postrst_C", C, 0);
    chk("postrst_in_ready", in_ready, 1);
    out_ready = 1;
    tick();
    chk("postrst_stale1", out_valid, 0);
    tick();
    chk("postrst_stale2", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
